ld3320_cmd_dispatch: RTL and testbench
======================================

// Module: ld3320_cmd_dispatch
// PURPOSE
//  Downstream consumer of the LD3320 voice front-end. Captures each recognised
//  code (result_valid qualified by a result_ready pulse), rejects out-of-range
//  codes and optionally suppresses repeats, then queues accepted commands in a
//  small FIFO with a valid/ready output handshake for the application logic.
//  It also drives the front-end enable.
// PARAMETERS
//  MAX_CODE      8'd15         highest legal code; 0 and codes > MAX_CODE are invalid
//  FIFO_DEPTH    4             queue entries, power of 2, >= 2
//  GUARD_CYCLES  24'd5000000   repeat-suppression window in clk cycles, >= 1
// PORTS
//  clk           in   1  system clock
//  sys_rst       in   1  asynchronous reset, active-high
//  enable        in   1  level; 1 = accept results and run the front-end
//  asr_ena       out  1  enable to the LD3320 front-end (registered copy of enable)
//  result_valid  in   8  recognised code from the front-end
//  result_ready  in   1  code strobe; may last >= 1 cycle, only its rising edge counts
//  cmd_code      out  8  FIFO head code
//  cmd_valid     out  1  FIFO not empty
//  cmd_ready     in   1  consumer pops the head when cmd_valid & cmd_ready
//  fifo_count    out  $clog2(FIFO_DEPTH)+1  entries currently queued
//  overflow      out  1  sticky: a result was lost. Cleared only by reset.
//  invalid_cnt   out  8  count of rejected codes, saturates at 8'hFF
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, FIFO empty, guard timer 0, last_code 0.
//  Edge detect: rdy_q <= result_ready; edge = result_ready & ~rdy_q. On edge,
//   cap_code <= result_valid (same cycle as edge, registered).
//  FSM:
//   IDLE     -> WAIT_RES when enable=1.
//   WAIT_RES -> CHECK on edge. -> IDLE when enable=0, which has priority over edge.
//   CHECK    (1 cycle) invalid (cap_code==0 or cap_code>MAX_CODE): invalid_cnt+1
//            (saturating), -> WAIT_RES.
//            Repeat (see CONFIGURATION): -> WAIT_RES, no push.
//            Otherwise -> PUSH.
//   PUSH     (1 cycle) write cap_code to FIFO tail, last_code<=cap_code, guard
//            timer<=GUARD_CYCLES-1. -> WAIT_RES.
//            FIFO full: no write, overflow<=1, timer and last_code unchanged.
//  An edge while in CHECK or PUSH is dropped and sets overflow=1.
//  Edges in IDLE are ignored without a flag.
//  Leaving to IDLE keeps the FIFO contents and the handshake remains active.
//  Guard timer: decrements by 1 per cycle while nonzero. It is "running" when nonzero.
//  FIFO: circular buffer, ptr wrap at FIFO_DEPTH.
//   cmd_code and cmd_valid reflect the head combinationally from registers.
//   Pop when cmd_valid & cmd_ready.
//   Push and pop in the same cycle: both happen; a full FIFO accepts the push
//   because the pop frees the slot; fifo_count is unchanged.
//   Pop on empty: no effect.
//  asr_ena <= enable, with 1-cycle latency.
//  Latency: edge cycle N -> CHECK N+1 -> PUSH N+2 -> cmd_valid=1 at N+3
//   when the FIFO was empty.
// CONFIGURATION
//  GUARD_FILTER_EN defined: in CHECK, a valid cap_code == last_code while the
//   guard timer is running is a repeat and is dropped silently.
//   A different code is always pushed and restarts the window.
//  GUARD_FILTER_EN undefined: no repeat filtering; every valid code is pushed.
//   The guard timer and last_code logic are not instantiated.
// TESTING
//  1 reset, enable=1, result_valid=8'h03 with a 1-cycle result_ready
//    -> cmd_valid=1 with cmd_code=8'h03 exactly 3 cycles after the edge;
//    cmd_ready=1 -> fifo_count returns to 0.
//  2 codes 8'h00, 8'h10, 8'hFF with MAX_CODE=15
//    -> invalid_cnt=3, nothing queued; 300 invalid codes -> invalid_cnt=8'hFF.
//  3 cmd_ready=0, push 5 valid distinct codes with FIFO_DEPTH=4
//    -> fifo_count=4, overflow=1; pops return the first 4 codes in order.
//  4 GUARD_FILTER_EN defined, GUARD_CYCLES=100: code 5 twice 50 cycles apart
//    -> one entry; code 5 again 150 cycles after the first -> second entry.
//    GUARD_FILTER_EN undefined: three entries.
//  5 FIFO full with cmd_ready=1 and a PUSH in the same cycle
//    -> fifo_count stays 4, overflow stays 0.
//    Result_ready edge during CHECK -> overflow=1.
//  6 assert sys_rst mid-PUSH with 2 entries queued
//    -> all outputs 0 immediately (asynchronous). enable=0 held low: asr_ena=0
//    and later edges are ignored.

Source files
------------

// File: rtl/ld3320_cmd_dispatch.sv
// ld3320_cmd_dispatch: captures recognised codes from the LD3320 front-end,
// rejects out-of-range codes and queues accepted commands in a small FIFO
// with a valid/ready handshake toward the application logic.
// Optional repeat suppression window is built when GUARD_FILTER_EN is defined.
module ld3320_cmd_dispatch #(
    parameter logic [7:0]  MAX_CODE     = 8'd15,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter logic [23:0] GUARD_CYCLES = 24'd5000000
) (
    input  logic                          clk,
    input  logic                          sys_rst,
    input  logic                          enable,
    output logic                          asr_ena,
    input  logic [7:0]                    result_valid,
    input  logic                          result_ready,
    output logic [7:0]                    cmd_code,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic [7:0]                    invalid_cnt
);

    localparam int unsigned CODE_W  = 8;
    localparam int unsigned GUARD_W = 24;
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_RES = 2'd1,
        ST_CHECK    = 2'd2,
        ST_PUSH     = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic                rdy_q, rdy_d;
    logic                asr_ena_q, asr_ena_d;
    logic [CODE_W-1:0]   cap_code_q, cap_code_d;
    logic [CODE_W-1:0]   invalid_cnt_q, invalid_cnt_d;
    logic                overflow_q, overflow_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CODE_W-1:0]   mem_q [FIFO_DEPTH];
    logic [CODE_W-1:0]   mem_d [FIFO_DEPTH];

    logic rise_c;
    logic invalid_c;
    logic repeat_c;
    logic capture_c;
    logic check_bad_c;
    logic push_req_c;
    logic drop_edge_c;
    logic full_c;
    logic pop_c;
    logic push_c;

    assign rise_c    = result_ready & ~rdy_q;
    assign invalid_c = (cap_code_q == '0) || (cap_code_q > MAX_CODE);

    // FSM state register
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; disable in WAIT_RES wins over a new strobe
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_WAIT_RES;
            end
            ST_WAIT_RES: begin
                if (!enable)     state_d = ST_IDLE;
                else if (rise_c) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (invalid_c || repeat_c) state_d = ST_WAIT_RES;
                else                       state_d = ST_PUSH;
            end
            ST_PUSH: begin
                state_d = ST_WAIT_RES;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM decoded controls for the datapath
    always_comb begin
        capture_c   = 1'b0;
        check_bad_c = 1'b0;
        push_req_c  = 1'b0;
        drop_edge_c = 1'b0;
        case (state_q)
            ST_WAIT_RES: capture_c = enable & rise_c;
            ST_CHECK: begin
                check_bad_c = invalid_c;
                drop_edge_c = rise_c;
            end
            ST_PUSH: begin
                push_req_c  = 1'b1;
                drop_edge_c = rise_c;
            end
            default: ;
        endcase
    end

`ifdef GUARD_FILTER_EN
    logic [CODE_W-1:0]  last_code_q, last_code_d;
    logic [GUARD_W-1:0] guard_q, guard_d;

    assign repeat_c = (cap_code_q == last_code_q) && (guard_q != '0);

    // Repeat window: reload on every accepted write, count down otherwise
    always_comb begin
        last_code_d = last_code_q;
        guard_d     = guard_q;
        if (guard_q != '0) guard_d = guard_q - GUARD_W'(1);
        if (push_c) begin
            last_code_d = cap_code_q;
            guard_d     = GUARD_CYCLES - GUARD_W'(1);
        end
    end

    // Repeat window registers
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            last_code_q <= '0;
            guard_q     <= '0;
        end else begin
            last_code_q <= last_code_d;
            guard_q     <= guard_d;
        end
    end
`else
    logic unused_guard_c;
    assign repeat_c       = 1'b0;
    assign unused_guard_c = ^GUARD_CYCLES;
`endif

    assign full_c = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop_c  = cmd_valid & cmd_ready;
    // a full queue still takes the write when the head leaves in the same cycle
    assign push_c = push_req_c & (~full_c | pop_c);

    // Datapath next state: strobe edge, capture, counters, FIFO
    always_comb begin
        rdy_d         = result_ready;
        asr_ena_d     = enable;
        cap_code_d    = cap_code_q;
        invalid_cnt_d = invalid_cnt_q;
        overflow_d    = overflow_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        mem_d         = mem_q;

        if (capture_c) cap_code_d = result_valid;

        if (check_bad_c && (invalid_cnt_q != 8'hFF)) begin
            invalid_cnt_d = invalid_cnt_q + CODE_W'(1);
        end

        if (drop_edge_c || (push_req_c && !push_c)) overflow_d = 1'b1;

        if (push_c) begin
            mem_d[wr_ptr_q] = cap_code_q;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            rdy_q         <= 1'b0;
            asr_ena_q     <= 1'b0;
            cap_code_q    <= '0;
            invalid_cnt_q <= '0;
            overflow_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rdy_q         <= rdy_d;
            asr_ena_q     <= asr_ena_d;
            cap_code_q    <= cap_code_d;
            invalid_cnt_q <= invalid_cnt_d;
            overflow_q    <= overflow_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            mem_q         <= mem_d;
        end
    end

    assign asr_ena     = asr_ena_q;
    assign cmd_code    = mem_q[rd_ptr_q];
    assign cmd_valid   = (count_q != '0);
    assign fifo_count  = count_q;
    assign overflow    = overflow_q;
    assign invalid_cnt = invalid_cnt_q;

endmodule

// File: tb/tb_ld3320_cmd_dispatch.sv
// Testbench for ld3320_cmd_dispatch: directed scenarios plus a randomized run,
// all checked against a transaction-level model of the command queue.
module tb_ld3320_cmd_dispatch;

    localparam int MAXC  = 15;
    localparam int DEPTH = 4;
    localparam int GUARD = 100;
`ifdef GUARD_FILTER_EN
    localparam bit GUARD_ON = 1'b1;
`else
    localparam bit GUARD_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       sys_rst;
    logic       enable;
    logic       asr_ena;
    logic [7:0] result_valid;
    logic       result_ready;
    logic [7:0] cmd_code;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] fifo_count;
    logic       overflow;
    logic [7:0] invalid_cnt;

    int checks   = 0;
    int failures = 0;

    ld3320_cmd_dispatch #(
        .MAX_CODE    (8'd15),
        .FIFO_DEPTH  (4),
        .GUARD_CYCLES(24'd100)
    ) dut (
        .clk         (clk),
        .sys_rst     (sys_rst),
        .enable      (enable),
        .asr_ena     (asr_ena),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .cmd_code    (cmd_code),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .invalid_cnt (invalid_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- transaction-level reference model ----------------
    logic [7:0] mq[$];
    bit         m_ovf;
    int         m_inv;
    bit         m_asr;
    bit         m_listen;      // front-end accepting (not idle)
    bit         pend_check;    // a captured code is evaluated at next edge
    logic [7:0] pc;
    bit         pend_push;     // an accepted code is written at next edge
    logic [7:0] pp;
    bit         prev_rr;
    int         cyc = 0;
    logic [7:0] last_code;
    int         last_push_cyc;

    task automatic model_reset();
        mq.delete();
        m_ovf = 0; m_inv = 0; m_asr = 0; m_listen = 0;
        pend_check = 0; pend_push = 0; prev_rr = 0;
        pc = 8'h00; pp = 8'h00;
        last_code = 8'h00;
        last_push_cyc = cyc - 100000;
    endtask

    // Effect of the coming clock edge given the inputs currently driven
    task automatic model_step();
        int t;
        bit pop, rise, busy, nxt_check, nxt_push;
        logic [7:0] nxt_pc, nxt_pp;
        t = cyc + 1;
        pop = cmd_ready && (mq.size() > 0);
        rise = result_ready && !prev_rr;
        busy = pend_check || pend_push;
        nxt_check = 0; nxt_push = 0; nxt_pc = 8'h00; nxt_pp = 8'h00;
        if (pend_check) begin
            if (pc == 8'h00 || int'(pc) > MAXC) begin
                if (m_inv < 255) m_inv++;
            end else if (!(GUARD_ON && pc == last_code && (t - last_push_cyc) < GUARD)) begin
                nxt_push = 1; nxt_pp = pc;
            end
        end
        if (rise) begin
            if (busy) m_ovf = 1;
            else if (m_listen && enable) begin nxt_check = 1; nxt_pc = result_valid; end
        end
        if (pop) void'(mq.pop_front());
        if (pend_push) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(pp); last_code = pp; last_push_cyc = t;
            end else begin
                m_ovf = 1;
            end
        end
        if (!busy) m_listen = enable;
        m_asr = enable;
        pend_check = nxt_check; pc = nxt_pc;
        pend_push = nxt_push; pp = nxt_pp;
        prev_rr = result_ready;
        cyc = t;
    endtask

    // One clock: model advances, DUT advances, return at the falling edge
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic strobe(input logic [7:0] code, input int hold);
        result_valid = code;
        result_ready = 1'b1;
        for (int i = 0; i < hold; i++) tick();
        result_ready = 1'b0;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1; enable = 1'b0; result_ready = 1'b0;
        result_valid = 8'h00; cmd_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        sys_rst = 1'b0;
    endtask

    task automatic start();
        do_reset();
        enable = 1'b1;
        idle(3);
    endtask

    // ------------------------------ tests ------------------------------
    task automatic test_reset();
        do_reset();
        checks += 6;
        if (asr_ena !== 1'b0)     begin failures++; $display("FAIL reset_asr_ena got=%0b exp=0", asr_ena); end
        if (cmd_code !== 8'h00)   begin failures++; $display("FAIL reset_cmd_code got=%0h exp=0", cmd_code); end
        if (cmd_valid !== 1'b0)   begin failures++; $display("FAIL reset_cmd_valid got=%0b exp=0", cmd_valid); end
        if (fifo_count !== 3'd0)  begin failures++; $display("FAIL reset_fifo_count got=%0d exp=0", fifo_count); end
        if (overflow !== 1'b0)    begin failures++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
        if (invalid_cnt !== 8'h0) begin failures++; $display("FAIL reset_invalid_cnt got=%0d exp=0", invalid_cnt); end
    endtask

    task automatic test_latency();
        start();
        strobe(8'h03, 1);                      // edge at this clock
        checks++;
        if (cmd_valid !== 1'b0) begin failures++; $display("FAIL lat_edge_plus1 got=%0b exp=0", cmd_valid); end
        tick();
        checks++;
        if (cmd_valid !== 1'b0) begin failures++; $display("FAIL lat_edge_plus2 got=%0b exp=0", cmd_valid); end
        tick();
        checks += 3;
        if (cmd_valid !== 1'b1)  begin failures++; $display("FAIL lat_edge_plus3 got=%0b exp=1", cmd_valid); end
        if (cmd_code !== 8'h03)  begin failures++; $display("FAIL lat_code got=%0h exp=03", cmd_code); end
        if (asr_ena !== 1'b1)    begin failures++; $display("FAIL lat_asr_ena got=%0b exp=1", asr_ena); end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        checks += 2;
        if (fifo_count !== 3'd0) begin failures++; $display("FAIL lat_pop_count got=%0d exp=0", fifo_count); end
        if (int'(fifo_count) != mq.size()) begin failures++; $display("FAIL lat_model_count got=%0d exp=%0d", fifo_count, mq.size()); end
    endtask

    task automatic test_invalid();
        logic [7:0] bad [3];
        logic [7:0] c;
        bad[0] = 8'h00; bad[1] = 8'h10; bad[2] = 8'hFF;
        start();
        for (int i = 0; i < 3; i++) begin strobe(bad[i], 1); idle(3); end
        checks += 2;
        if (invalid_cnt !== 8'd3) begin failures++; $display("FAIL inv_three got=%0d exp=3", invalid_cnt); end
        if (fifo_count !== 3'd0)  begin failures++; $display("FAIL inv_nothing_queued got=%0d exp=0", fifo_count); end
        for (int i = 0; i < 300; i++) begin
            c = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(16, 255));
            strobe(c, 1);
            idle(2);
        end
        checks += 2;
        if (invalid_cnt !== 8'hFF) begin failures++; $display("FAIL inv_saturate got=%0d exp=255", invalid_cnt); end
        if (int'(invalid_cnt) != m_inv) begin failures++; $display("FAIL inv_model got=%0d exp=%0d", invalid_cnt, m_inv); end
    endtask

    task automatic test_overflow();
        logic [7:0] codes [5];
        logic [7:0] pool [$];
        int k;
        for (int i = 1; i <= MAXC; i++) pool.push_back(8'(i));
        for (int i = 0; i < 5; i++) begin
            k = $urandom_range(0, pool.size() - 1);
            codes[i] = pool[k];
            pool.delete(k);
        end
        start();
        for (int i = 0; i < 5; i++) begin strobe(codes[i], 1); idle(4); end
        checks += 2;
        if (fifo_count !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", fifo_count); end
        if (overflow !== 1'b1)   begin failures++; $display("FAIL ovf_flag got=%0b exp=1", overflow); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cmd_code !== codes[i]) begin failures++; $display("FAIL ovf_pop%0d got=%0h exp=%0h", i, cmd_code, codes[i]); end
            cmd_ready = 1'b1;
            tick();
            cmd_ready = 1'b0;
        end
        checks += 2;
        if (cmd_valid !== 1'b0) begin failures++; $display("FAIL ovf_drained got=%0b exp=0", cmd_valid); end
        if (overflow !== 1'b1)  begin failures++; $display("FAIL ovf_sticky got=%0b exp=1", overflow); end
    endtask

    task automatic test_guard();
        int exp_n;
        start();
        strobe(8'h05, 1);
        idle(49);
        strobe(8'h05, 1);                      // 50 cycles after the first
        idle(99);
        strobe(8'h05, 1);                      // 150 cycles after the first
        idle(4);
        exp_n = GUARD_ON ? 2 : 3;
        checks += 2;
        if (int'(fifo_count) != exp_n) begin failures++; $display("FAIL guard_entries got=%0d exp=%0d", fifo_count, exp_n); end
        if (int'(fifo_count) != mq.size()) begin failures++; $display("FAIL guard_model got=%0d exp=%0d", fifo_count, mq.size()); end
        for (int i = 0; i < exp_n; i++) begin
            checks++;
            if (cmd_code !== 8'h05) begin failures++; $display("FAIL guard_code%0d got=%0h exp=05", i, cmd_code); end
            cmd_ready = 1'b1;
            tick();
            cmd_ready = 1'b0;
        end
    endtask

    task automatic test_full_push_pop();
        start();
        for (int i = 1; i <= 4; i++) begin strobe(8'(i), 1); idle(4); end
        strobe(8'h09, 1);                      // edge
        tick();                                // CHECK
        cmd_ready = 1'b1;
        tick();                                // PUSH coincides with pop
        cmd_ready = 1'b0;
        checks += 3;
        if (fifo_count !== 3'd4) begin failures++; $display("FAIL fpp_count got=%0d exp=4", fifo_count); end
        if (overflow !== 1'b0)   begin failures++; $display("FAIL fpp_overflow got=%0b exp=0", overflow); end
        if (cmd_code !== 8'h02)  begin failures++; $display("FAIL fpp_head got=%0h exp=02", cmd_code); end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        strobe(8'h0A, 1);                      // accepted
        idle(1);
        strobe(8'h0B, 1);                      // arrives while the first is still busy
        idle(4);
        checks += 3;
        if (overflow !== 1'b1)   begin failures++; $display("FAIL drop_overflow got=%0b exp=1", overflow); end
        if (fifo_count !== 3'd4) begin failures++; $display("FAIL drop_count got=%0d exp=4", fifo_count); end
        if (int'(fifo_count) != mq.size()) begin failures++; $display("FAIL drop_model got=%0d exp=%0d", fifo_count, mq.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cmd_code !== mq[0]) begin failures++; $display("FAIL drop_pop%0d got=%0h exp=%0h", i, cmd_code, mq[0]); end
            cmd_ready = 1'b1;
            tick();
            cmd_ready = 1'b0;
        end
    endtask

    task automatic test_reset_mid_push();
        start();
        strobe(8'h07, 1); idle(4);
        strobe(8'h08, 1); idle(4);
        checks++;
        if (fifo_count !== 3'd2) begin failures++; $display("FAIL rmp_two got=%0d exp=2", fifo_count); end
        strobe(8'h0C, 1);
        tick();                                // now sitting in PUSH
        sys_rst = 1'b1;
        #1;
        checks += 6;
        if (asr_ena !== 1'b0)     begin failures++; $display("FAIL rmp_asr_ena got=%0b exp=0", asr_ena); end
        if (cmd_code !== 8'h00)   begin failures++; $display("FAIL rmp_cmd_code got=%0h exp=0", cmd_code); end
        if (cmd_valid !== 1'b0)   begin failures++; $display("FAIL rmp_cmd_valid got=%0b exp=0", cmd_valid); end
        if (fifo_count !== 3'd0)  begin failures++; $display("FAIL rmp_fifo_count got=%0d exp=0", fifo_count); end
        if (overflow !== 1'b0)    begin failures++; $display("FAIL rmp_overflow got=%0b exp=0", overflow); end
        if (invalid_cnt !== 8'h0) begin failures++; $display("FAIL rmp_invalid_cnt got=%0d exp=0", invalid_cnt); end
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        sys_rst = 1'b0;
        idle(3);
        for (int i = 0; i < 3; i++) begin strobe(8'(i + 1), 1); idle(3); end
        strobe(8'h20, 1); idle(3);
        checks += 4;
        if (asr_ena !== 1'b0)     begin failures++; $display("FAIL dis_asr_ena got=%0b exp=0", asr_ena); end
        if (cmd_valid !== 1'b0)   begin failures++; $display("FAIL dis_cmd_valid got=%0b exp=0", cmd_valid); end
        if (fifo_count !== 3'd0)  begin failures++; $display("FAIL dis_fifo_count got=%0d exp=0", fifo_count); end
        if (invalid_cnt !== 8'h0) begin failures++; $display("FAIL dis_invalid_cnt got=%0d exp=0", invalid_cnt); end
    endtask

    task automatic test_random();
        int hold, gap;
        logic [7:0] c;
        start();
        for (int it = 0; it < 400; it++) begin
            enable = ($urandom_range(0, 15) != 0);
            c = ($urandom_range(0, 9) < 7) ? 8'($urandom_range(1, 4)) : 8'($urandom_range(0, 255));
            hold = $urandom_range(1, 2);
            gap  = $urandom_range(1, 5);
            result_valid = c;
            for (int s = 0; s < hold + gap; s++) begin
                result_ready = (s < hold);
                cmd_ready = ($urandom_range(0, 3) == 0);
                tick();
                checks += 5;
                if (int'(fifo_count) != mq.size()) begin failures++; $display("FAIL rnd_count it=%0d got=%0d exp=%0d", it, fifo_count, mq.size()); end
                if (cmd_valid !== (mq.size() > 0)) begin failures++; $display("FAIL rnd_valid it=%0d got=%0b exp=%0b", it, cmd_valid, mq.size() > 0); end
                if (overflow !== m_ovf) begin failures++; $display("FAIL rnd_overflow it=%0d got=%0b exp=%0b", it, overflow, m_ovf); end
                if (int'(invalid_cnt) != m_inv) begin failures++; $display("FAIL rnd_invalid it=%0d got=%0d exp=%0d", it, invalid_cnt, m_inv); end
                if (asr_ena !== m_asr) begin failures++; $display("FAIL rnd_asr_ena it=%0d got=%0b exp=%0b", it, asr_ena, m_asr); end
                if (mq.size() > 0) begin
                    checks++;
                    if (cmd_code !== mq[0]) begin failures++; $display("FAIL rnd_code it=%0d got=%0h exp=%0h", it, cmd_code, mq[0]); end
                end
            end
        end
        result_ready = 1'b0;
        cmd_ready = 1'b0;
    endtask

    initial begin
        sys_rst = 1'b1; enable = 1'b0; result_valid = 8'h00;
        result_ready = 1'b0; cmd_ready = 1'b0;
        model_reset();
        test_reset();
        test_latency();
        test_invalid();
        test_overflow();
        test_guard();
        test_full_push_pop();
        test_reset_mid_push();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
